adc_stats: RTL

ADC_STATS -- requirements
Module: adc_stats

---
 rtl/adc_stats.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/adc_stats.sv
// adc_stats: toggle-strobed ADC sample capture, power-of-two moving average,
// windowed min/max/mean statistics and an optional hysteresis comparator.
// Optional feature: define ADC_STATS_HYST_EN to build the comparator on dig_out;
// without it dig_out is tied low and hist_low/hist_high are ignored.
module adc_stats #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned WIN_LOG2 = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_sync,
  input  logic [WIDTH-1:0] hist_low,
  input  logic [WIDTH-1:0] hist_high,
  output logic [WIDTH-1:0] avg,
  output logic             avg_valid,
  output logic [WIDTH-1:0] win_min,
  output logic [WIDTH-1:0] win_max,
  output logic [WIDTH-1:0] win_mean,
  output logic             stats_valid,
  output logic             dig_out
);

  localparam int unsigned AvgLen   = 1 << AVG_LOG2;
  localparam int unsigned AvgSumW  = WIDTH + AVG_LOG2;
  localparam int unsigned WinSumW  = WIDTH + WIN_LOG2;
  localparam int unsigned FillCntW = AVG_LOG2 + 1;

  typedef enum logic [0:0] {StFill, StRun} state_e;

  state_e               state_q, state_d;
  logic                 sync_d;
  logic                 accept;
  logic [WIDTH-1:0]     shreg_q [AvgLen];
  logic [AvgSumW-1:0]   avg_sum_q, avg_sum_d;
  logic [WIDTH-1:0]     avg_q;
  logic                 avg_upd_q;
  logic [FillCntW-1:0]  fill_cnt_q;
  logic                 fill_last;
  logic                 win_upd, win_wrap;
  logic [WIDTH-1:0]     run_min_q, run_max_q, run_min_nxt, run_max_nxt;
  logic [WinSumW-1:0]   run_sum_q, run_sum_nxt;
  logic [WIN_LOG2-1:0]  win_cnt_q;
  logic [WIDTH-1:0]     win_min_q, win_max_q, win_mean_q;
  logic                 stats_valid_q;

  // Strobe history; loaded even during reset so release never looks like an edge.
  always_ff @(posedge clk) begin
    sync_d <= din_sync;
  end

  assign accept    = (din_sync != sync_d);
  assign fill_last = (fill_cnt_q == FillCntW'(AvgLen - 1));

  // Running sum: add the incoming sample, drop the one falling off the shift register.
  always_comb begin
    avg_sum_d = avg_sum_q + AvgSumW'(din) - AvgSumW'(shreg_q[AvgLen-1]);
  end

  // Averager shift register, running sum, registered average and update flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(AvgLen); i++) shreg_q[i] <= '0;
      avg_sum_q <= '0;
      avg_q     <= '0;
      avg_upd_q <= 1'b0;
    end else begin
      avg_upd_q <= accept;
      if (accept) begin
        shreg_q[0] <= din;
        for (int i = 1; i < int'(AvgLen); i++) shreg_q[i] <= shreg_q[i-1];
        avg_sum_q <= avg_sum_d;
        avg_q     <= WIDTH'(avg_sum_d >> AVG_LOG2);
      end
    end
  end

  // FSM state register and fill counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StFill;
      fill_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == StFill) fill_cnt_q <= fill_cnt_q + 1'b1;
    end
  end

  // FSM next state: leave FILL on the sample that completes the averager.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (accept && fill_last) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StFill;
    endcase
  end

  // FSM outputs: RUN is entered on the same edge as the first full average.
  always_comb begin
    avg_valid = 1'b0;
    unique case (state_q)
      StFill:  avg_valid = 1'b0;
      StRun:   avg_valid = 1'b1;
      default: avg_valid = 1'b0;
    endcase
  end

  // An avg update counts for the window only if it left the FSM in RUN.
  assign win_upd  = avg_upd_q && avg_valid;
  assign win_wrap = win_upd && (win_cnt_q == {WIN_LOG2{1'b1}});

  // Accumulator values including the current average.
  always_comb begin
    run_min_nxt = (avg_q < run_min_q) ? avg_q : run_min_q;
    run_max_nxt = (avg_q > run_max_q) ? avg_q : run_max_q;
    run_sum_nxt = run_sum_q + WinSumW'(avg_q);
  end

  // Window accumulators; on wrap publish results and restart from empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_min_q     <= '1;
      run_max_q     <= '0;
      run_sum_q     <= '0;
      win_cnt_q     <= '0;
      win_min_q     <= '0;
      win_max_q     <= '0;
      win_mean_q    <= '0;
      stats_valid_q <= 1'b0;
    end else begin
      stats_valid_q <= win_wrap;
      if (win_upd) begin
        win_cnt_q <= win_cnt_q + 1'b1;
        if (win_wrap) begin
          win_min_q  <= run_min_nxt;
          win_max_q  <= run_max_nxt;
          win_mean_q <= WIDTH'(run_sum_nxt >> WIN_LOG2);
          run_min_q  <= '1;
          run_max_q  <= '0;
          run_sum_q  <= '0;
        end else begin
          run_min_q <= run_min_nxt;
          run_max_q <= run_max_nxt;
          run_sum_q <= run_sum_nxt;
        end
      end
    end
  end

`ifdef ADC_STATS_HYST_EN
  logic dig_q;

  // Hysteresis comparator; inverted thresholds freeze the output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dig_q <= 1'b0;
    end else if (win_upd && (hist_low <= hist_high)) begin
      if (avg_q > hist_high) begin
        dig_q <= 1'b1;
      end else if (avg_q < hist_low) begin
        dig_q <= 1'b0;
      end
    end
  end

  assign dig_out = dig_q;
`else
  logic unused_hist;
  assign unused_hist = ^{hist_low, hist_high};
  assign dig_out     = 1'b0;
`endif

  assign avg         = avg_q;
  assign win_min     = win_min_q;
  assign win_max     = win_max_q;
  assign win_mean    = win_mean_q;
  assign stats_valid = stats_valid_q;

endmodule
